sa_feed_ctrl: RTL and testbench

SA_FEED_CTRL -- requirements
Module: sa_feed_ctrl

---
 rtl/sa_pkg.sv | 24 ++
 rtl/sa_feed_ctrl_if.sv | 37 +++
 rtl/sa_skew_mux.sv | 26 ++
 rtl/sa_feed_ctrl.sv | 144 ++++++++++++++
 tb/tb_sa_feed_ctrl.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sa_pkg.sv
// Shared types and defaults for the systolic-array feed controller.
// State encoding plus the skew index helper used by every lane mux.
package sa_pkg;

  localparam int SA_N         = 4;
  localparam int SA_DATA_W    = 32;
  localparam int SA_DRAIN_MAX = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_DONE
  } state_e;

  function automatic int skew_idx(
    input int t,
    input int lane
  );
    return t - lane;
  endfunction

endpackage

// File: rtl/sa_feed_ctrl_if.sv
// Operand load, run control and array-facing stream bundle.
// The controller takes the slave side; the driver/array model the master side.
interface sa_feed_ctrl_if
  import sa_pkg::*;
#(
  parameter int N      = SA_N,
  parameter int DATA_W = SA_DATA_W
);

  logic              wr_en;
  logic              wr_sel;
  logic [3:0]        wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              start;
  logic              sa_done;
  logic              sa_rst;
  logic [DATA_W-1:0] inp_west  [N];
  logic [DATA_W-1:0] inp_north [N];
  logic              busy;
  logic              result_valid;
  logic              timeout_err;

  modport slave (
    input  wr_en, wr_sel, wr_addr, wr_data,
    input  start, sa_done,
    output sa_rst, inp_west, inp_north,
    output busy, result_valid, timeout_err
  );

  modport master (
    output wr_en, wr_sel, wr_addr, wr_data,
    output start, sa_done,
    input  sa_rst, inp_west, inp_north,
    input  busy, result_valid, timeout_err
  );

endinterface

// File: rtl/sa_skew_mux.sv
// Picks element (t - LANE) of one row/column, or zero outside the
// lane's diagonal window.
module sa_skew_mux
  import sa_pkg::*;
#(
  parameter int N      = SA_N,
  parameter int DATA_W = SA_DATA_W,
  parameter int TW     = 3,
  parameter int LANE   = 0
) (
  input  logic [TW-1:0]     t_i,
  input  logic [DATA_W-1:0] vec_i [N],
  output logic [DATA_W-1:0] elem_o
);

  int idx;

  always_comb begin
    elem_o = '0;
    idx    = skew_idx(int'(t_i), LANE);
    for (int k = 0; k < N; k++) begin
      if (idx == k) elem_o = vec_i[k];
    end
  end

endmodule

// File: rtl/sa_feed_ctrl.sv
// Operand buffers and run FSM that feed skewed A rows / B columns
// into an N x N systolic array and wait for its completion flag.
module sa_feed_ctrl
  import sa_pkg::*;
#(
  parameter int N         = SA_N,
  parameter int DATA_W    = SA_DATA_W,
  parameter int DRAIN_MAX = SA_DRAIN_MAX
) (
  input logic           clk,
  input logic           rst,
  sa_feed_ctrl_if.slave bus
);

  localparam int TW = $clog2(2 * N);
  localparam int CW = $clog2(DRAIN_MAX + 1);
  localparam logic [TW-1:0] T_LAST = TW'(2 * N - 2);
  localparam logic [CW-1:0] D_LAST = CW'(DRAIN_MAX - 1);

  state_e            state_q, state_d;
  logic [TW-1:0]     t_q, t_d;
  logic [CW-1:0]     drn_q, drn_d;
  logic              tmo_q, tmo_d;
  logic [DATA_W-1:0] a_q [N*N];
  logic [DATA_W-1:0] b_q [N*N];
  logic [DATA_W-1:0] west_q [N];
  logic [DATA_W-1:0] north_q [N];
  logic [DATA_W-1:0] west_d [N];
  logic [DATA_W-1:0] north_d [N];
  logic              feed_d;
  logic              wr_ok;

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    drn_d   = drn_q;
    tmo_d   = tmo_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_CLEAR;
          tmo_d   = 1'b0;
        end
      end
      S_CLEAR: begin
        state_d = S_FEED;
        t_d     = '0;
      end
      S_FEED: begin
        if (t_q == T_LAST) begin
          state_d = S_DRAIN;
          t_d     = '0;
          drn_d   = '0;
        end else begin
          t_d = t_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (bus.sa_done) begin
          state_d = S_DONE;
        end else if (drn_q == D_LAST) begin
          state_d = S_DONE;
          tmo_d   = 1'b1;
        end else begin
          drn_d = drn_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Streams are registered, so lanes select on the upcoming t.
  assign feed_d = (state_d == S_FEED);
  assign wr_ok  = (state_q == S_IDLE) && bus.wr_en
                  && (int'(bus.wr_addr) < N * N);

  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [DATA_W-1:0] row [N];
    logic [DATA_W-1:0] col [N];
    logic [DATA_W-1:0] w_sel;
    logic [DATA_W-1:0] n_sel;

    always_comb begin
      for (int k = 0; k < N; k++) begin
        row[k] = a_q[i*N+k];
        col[k] = b_q[k*N+i];
      end
    end

    sa_skew_mux #(
      .N(N), .DATA_W(DATA_W), .TW(TW), .LANE(i)
    ) u_west (
      .t_i(t_d), .vec_i(row), .elem_o(w_sel)
    );

    sa_skew_mux #(
      .N(N), .DATA_W(DATA_W), .TW(TW), .LANE(i)
    ) u_north (
      .t_i(t_d), .vec_i(col), .elem_o(n_sel)
    );

    assign west_d[i]  = feed_d ? w_sel : '0;
    assign north_d[i] = feed_d ? n_sel : '0;
    assign bus.inp_west[i]  = west_q[i];
    assign bus.inp_north[i] = north_q[i];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      t_q     <= '0;
      drn_q   <= '0;
      tmo_q   <= 1'b0;
      for (int k = 0; k < N * N; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
      end
      for (int k = 0; k < N; k++) begin
        west_q[k]  <= '0;
        north_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      drn_q   <= drn_d;
      tmo_q   <= tmo_d;
      if (wr_ok) begin
        if (bus.wr_sel) b_q[bus.wr_addr] <= bus.wr_data;
        else            a_q[bus.wr_addr] <= bus.wr_data;
      end
      for (int k = 0; k < N; k++) begin
        west_q[k]  <= west_d[k];
        north_q[k] <= north_d[k];
      end
    end
  end

  assign bus.sa_rst       = (state_q == S_CLEAR);
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.result_valid = (state_q == S_DONE);
  assign bus.timeout_err  = tmo_q;

endmodule

// File: tb/tb_sa_feed_ctrl.sv
// Directed bench for sa_feed_ctrl: stimulus queues expected snapshots,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_sa_feed_ctrl;

  localparam int N  = 4;
  localparam int DW = 32;

  typedef enum int {M_IDLE, M_CLEAR, M_FEED, M_DRAIN, M_DONE} mst_e;

  typedef struct packed {
    logic                 sa_rst;
    logic                 busy;
    logic                 rv;
    logic                 te;
    logic [N-1:0][DW-1:0] w;
    logic [N-1:0][DW-1:0] n;
  } snap_t;

  logic clk = 1'b0;
  logic rst;

  sa_feed_ctrl_if #(.N(N), .DATA_W(DW)) bus ();

  sa_feed_ctrl #(.N(N), .DATA_W(DW), .DRAIN_MAX(16)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  snap_t       exp_q [$];
  string       tag_q [$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [DW-1:0] ma [N*N];
  logic [DW-1:0] mb [N*N];
  bit          te_m;

  function automatic snap_t observe();
    snap_t r;
    r.sa_rst = bus.sa_rst;
    r.busy   = bus.busy;
    r.rv     = bus.result_valid;
    r.te     = bus.timeout_err;
    for (int i = 0; i < N; i++) begin
      r.w[i] = bus.inp_west[i];
      r.n[i] = bus.inp_north[i];
    end
    return r;
  endfunction

  function automatic snap_t mk(input mst_e s, input int t);
    snap_t r;
    int    k;
    r        = '0;
    r.te     = te_m;
    r.busy   = (s != M_IDLE);
    r.sa_rst = (s == M_CLEAR);
    r.rv     = (s == M_DONE);
    if (s == M_FEED) begin
      for (int i = 0; i < N; i++) begin
        k = t - i;
        if (k >= 0 && k < N) begin
          r.w[i] = ma[i*N+k];
          r.n[i] = mb[k*N+i];
        end
      end
    end
    return r;
  endfunction

  function automatic snap_t hand(input int t);
    snap_t r;
    r      = '0;
    r.busy = 1'b1;
    if (t == 3) begin
      r.w[0] = 3;  r.w[1] = 6; r.w[2] = 9; r.w[3] = 12;
      r.n[0] = 12; r.n[1] = 9; r.n[2] = 6; r.n[3] = 3;
    end
    if (t == 6) begin
      r.w[3] = 15;
      r.n[3] = 15;
    end
    return r;
  endfunction

  task automatic push(input string tg, input snap_t s);
    exp_q.push_back(s);
    tag_q.push_back(tg);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input bit sel, input int addr, input logic [DW-1:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_sel  = sel;
    bus.wr_addr = 4'(addr);
    bus.wr_data = d;
    tick();
    bus.wr_en = 1'b0;
    if (sel) mb[addr] = d;
    else     ma[addr] = d;
    push("load", mk(M_IDLE, 0));
  endtask

  task automatic do_run(input int done_at, input int guard_at,
                        input int abort_at, input bit hd);
    bit fin;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.wr_en = 1'b0;
    te_m      = 1'b0;
    push("clear", mk(M_CLEAR, 0));
    for (int t = 0; t < 2 * N - 1; t++) begin
      tick();
      bus.start = 1'b0;
      bus.wr_en = 1'b0;
      if (hd && (t == 0 || t == 3 || t == 6)) push($sformatf("hand_t%0d", t), hand(t));
      else push($sformatf("feed_t%0d", t), mk(M_FEED, t));
      if (t == guard_at) begin
        bus.wr_en   = 1'b1;
        bus.wr_sel  = 1'b0;
        bus.wr_addr = 4'd0;
        bus.wr_data = 32'd99;
        bus.start   = 1'b1;
      end
      if (t == abort_at) begin
        rst         = 1'b1;
        bus.start   = 1'b1;
        bus.wr_en   = 1'b1;
        bus.wr_sel  = 1'b0;
        bus.wr_addr = 4'd5;
        bus.wr_data = 32'hdead;
        tick();
        rst       = 1'b0;
        bus.start = 1'b0;
        bus.wr_en = 1'b0;
        for (int k = 0; k < N * N; k++) begin
          ma[k] = '0;
          mb[k] = '0;
        end
        te_m = 1'b0;
        push("abort", mk(M_IDLE, 0));
        return;
      end
    end
    fin = 1'b0;
    for (int k = 0; k < 16 && !fin; k++) begin
      tick();
      push($sformatf("drain%0d", k), mk(M_DRAIN, 0));
      if (k == done_at) begin
        bus.sa_done = 1'b1;
        tick();
        bus.sa_done = 1'b0;
        push("done", mk(M_DONE, 0));
        fin = 1'b1;
      end
    end
    if (!fin) begin
      tick();
      te_m = 1'b1;
      push("timeout", mk(M_DONE, 0));
    end
    tick();
    push("post_idle", mk(M_IDLE, 0));
  endtask

  initial begin : monitor
    snap_t e;
    snap_t g;
    string tg;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        tg = tag_q.pop_front();
        g  = observe();
        n_cmp++;
        if (g !== e) begin
          n_err++;
          $display("FAIL %s: got %h want %h", tg, g, e);
        end
      end
    end
  end

  initial begin : stim
    for (int k = 0; k < N * N; k++) begin
      ma[k] = '0;
      mb[k] = '0;
    end
    te_m        = 1'b0;
    rst         = 1'b1;
    bus.wr_en   = 1'b1;
    bus.wr_sel  = 1'b0;
    bus.wr_addr = 4'd0;
    bus.wr_data = 32'h55;
    bus.start   = 1'b1;
    bus.sa_done = 1'b0;
    tick();
    push("reset0", mk(M_IDLE, 0));
    tick();
    push("reset1", mk(M_IDLE, 0));
    rst       = 1'b0;
    bus.wr_en = 1'b0;
    bus.start = 1'b0;

    for (int k = 0; k < N * N; k++) wr(1'b0, k, DW'(k));
    for (int k = 0; k < N * N; k++) wr(1'b1, k, DW'(k));

    bus.sa_done = 1'b1;
    tick();
    bus.sa_done = 1'b0;
    push("idle_done_ign", mk(M_IDLE, 0));

    do_run(3, -1, -1, 1'b1);
    do_run(-1, -1, -1, 1'b0);
    tick();
    push("te_sticky", mk(M_IDLE, 0));

    do_run(0, 3, -1, 1'b0);
    tick();
    push("no_rerun", mk(M_IDLE, 0));
    do_run(1, -1, -1, 1'b0);

    bus.wr_en   = 1'b1;
    bus.wr_sel  = 1'b1;
    bus.wr_addr = 4'd0;
    bus.wr_data = 32'd7;
    mb[0]       = 32'd7;
    do_run(2, -1, -1, 1'b0);

    do_run(5, -1, 2, 1'b0);
    tick();
    push("abort_idle", mk(M_IDLE, 0));
    do_run(0, -1, -1, 1'b0);

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_queue: got %0d left want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
